// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        WAIT  = 2'b01,
        FAULT = 2'b10
    } pc_state_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] WB_SRC_LOAD = 2'b11;

    // MEM holds the younger result, so it wins over WB.
    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit)     return FWD_MEM;
        else if (wb_hit) return FWD_WB;
        else             return FWD_REG;
    endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Hazard-controller bundle: master = pipeline datapath, slave = pipeline_controller.
interface pipeline_controller_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) ();
    logic [REG_AW-1:0] id_rs1, id_rs2;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [1:0]        ex_wb_src;
    logic              ex_redirect;
    logic [REG_AW-1:0] mem_rd, wb_rd;
    logic              mem_reg_write, wb_reg_write;
    logic              mem_access, dmem_ready;

    logic              dmem_req;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_w;
    fwd_sel_t          fwd_a, fwd_b;
    logic              mem_fault;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_wb_src, ex_redirect,
               mem_rd, wb_rd, mem_reg_write, wb_reg_write, mem_access, dmem_ready,
        input  dmem_req, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, fwd_a, fwd_b, mem_fault
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_wb_src, ex_redirect,
               mem_rd, wb_rd, mem_reg_write, wb_reg_write, mem_access, dmem_ready,
        output dmem_req, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, fwd_a, fwd_b, mem_fault
    );
endinterface

// File: rtl/pipeline_controller_forward_unit.sv
// EX-stage operand forwarding selects; purely combinational.
module forward_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    output fwd_sel_t          fwd_a,
    output fwd_sel_t          fwd_b
);
    logic mem_ok, wb_ok;

    // x0 is hard-wired zero, so a write to it must never be forwarded.
    assign mem_ok = mem_reg_write && (mem_rd != '0);
    assign wb_ok  = wb_reg_write  && (wb_rd  != '0);

    assign fwd_a = fwd_pick(mem_ok && (mem_rd == ex_rs1), wb_ok && (wb_rd == ex_rs1));
    assign fwd_b = fwd_pick(mem_ok && (mem_rd == ex_rs2), wb_ok && (wb_rd == ex_rs2));
endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush/forwarding controller with dmem wait-state FSM and timeout fault.
// Optional PIPE_PERF_CNT_EN adds stall/flush/load-use performance counters.
module pipeline_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_controller_if.slave bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_events,
    output logic [31:0]          load_use_cnt
`endif
);
    pc_state_t        state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_fault;
    logic             mem_stall, redirect_act, load_use_hit, load_use_act, stall_front;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.mem_access && !bus.dmem_ready) begin
                        state    <= WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (bus.dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                        state     <= FAULT;
                        mem_fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                FAULT:   mem_fault <= 1'b1;
                default: state     <= RUN;
            endcase
        end
    end

    // A held redirect stays in the frozen E stage and fires once dmem_ready releases the stall.
    assign mem_stall    = (state == FAULT)
                        || ((state == WAIT) && !bus.dmem_ready)
                        || ((state == RUN)  && bus.mem_access && !bus.dmem_ready);
    assign redirect_act = !mem_stall && bus.ex_redirect;
    assign load_use_hit = (bus.ex_wb_src == WB_SRC_LOAD) && (bus.ex_rd != '0)
                        && ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
    assign load_use_act = !mem_stall && !bus.ex_redirect && load_use_hit;
    assign stall_front  = mem_stall || load_use_act;

    assign bus.dmem_req  = bus.mem_access && (state != FAULT);
    assign bus.stall_f   = stall_front;
    assign bus.stall_d   = stall_front;
    assign bus.stall_e   = mem_stall;
    assign bus.stall_m   = mem_stall;
    assign bus.flush_d   = redirect_act;
    assign bus.flush_e   = redirect_act || load_use_act;
    assign bus.flush_w   = mem_stall;
    assign bus.mem_fault = mem_fault;

    forward_unit #(.REG_AW(REG_AW)) u_forward_unit (
        .ex_rs1        (bus.ex_rs1),
        .ex_rs2        (bus.ex_rs2),
        .mem_rd        (bus.mem_rd),
        .wb_rd         (bus.wb_rd),
        .mem_reg_write (bus.mem_reg_write),
        .wb_reg_write  (bus.wb_reg_write),
        .fwd_a         (bus.fwd_a),
        .fwd_b         (bus.fwd_b)
    );

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
            load_use_cnt <= '0;
        end else begin
            if (stall_front)  stall_cycles <= stall_cycles + 32'd1;
            if (redirect_act) flush_events <= flush_events + 32'd1;
            if (load_use_act) load_use_cnt <= load_use_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: comb vector table plus multi-cycle FSM sequences.
module tb_pipeline_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipeline_controller_if #(.REG_AW(5)) bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events, load_use_cnt;
`endif

    pipeline_controller #(.REG_AW(5), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events),
        .load_use_cnt (load_use_cnt)
`endif
    );

    // Expected word layout: {req, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, fwd_a, fwd_b}
    typedef struct {
        string       name;
        logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
        logic [1:0]  ex_wb_src;
        logic        ex_redirect;
        logic [4:0]  mem_rd, wb_rd;
        logic        mem_reg_write, wb_reg_write, mem_access, dmem_ready;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [4:0] id_rs1, logic [4:0] id_rs2,
                                logic [4:0] ex_rs1, logic [4:0] ex_rs2, logic [4:0] ex_rd,
                                logic [1:0] ex_wb_src, logic ex_redirect,
                                logic [4:0] mem_rd, logic mrw, logic [4:0] wb_rd, logic wrw,
                                logic mem_access, logic dmem_ready, logic [11:0] exp);
        vec_t v;
        v.name = name; v.id_rs1 = id_rs1; v.id_rs2 = id_rs2;
        v.ex_rs1 = ex_rs1; v.ex_rs2 = ex_rs2; v.ex_rd = ex_rd;
        v.ex_wb_src = ex_wb_src; v.ex_redirect = ex_redirect;
        v.mem_rd = mem_rd; v.mem_reg_write = mrw; v.wb_rd = wb_rd; v.wb_reg_write = wrw;
        v.mem_access = mem_access; v.dmem_ready = dmem_ready; v.exp = exp;
        return v;
    endfunction

    function automatic logic [11:0] outs();
        return {bus.dmem_req, bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
                bus.flush_d, bus.flush_e, bus.flush_w, bus.fwd_a, bus.fwd_b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.id_rs1 = v.id_rs1; bus.id_rs2 = v.id_rs2;
        bus.ex_rs1 = v.ex_rs1; bus.ex_rs2 = v.ex_rs2; bus.ex_rd = v.ex_rd;
        bus.ex_wb_src = v.ex_wb_src; bus.ex_redirect = v.ex_redirect;
        bus.mem_rd = v.mem_rd; bus.mem_reg_write = v.mem_reg_write;
        bus.wb_rd = v.wb_rd; bus.wb_reg_write = v.wb_reg_write;
        bus.mem_access = v.mem_access; bus.dmem_ready = v.dmem_ready;
    endtask

    task automatic clear_inputs();
        apply(mk("idle", 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 12'b0));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    // Drive current inputs, sample at the falling edge, then move past the next rising edge.
    task automatic check_cycle(input string name, input logic [11:0] exp);
        @(negedge clk);
        check(name, 32'(outs()), 32'(exp));
        next_cycle();
    endtask

    initial begin
        //          name          idr1 idr2 exr1 exr2 exrd src  redir mrd mrw wrd wrw macc rdy  expected
        vecs.push_back(mk("zero",        0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 12'b0_0000_000_00_00));
        vecs.push_back(mk("fwd_mem_a",   0, 0, 5, 0, 0, 2'b00, 0, 5, 1, 5, 1, 0, 0, 12'b0_0000_000_10_00));
        vecs.push_back(mk("fwd_wb_a",    0, 0, 5, 0, 0, 2'b00, 0, 0, 1, 5, 1, 0, 0, 12'b0_0000_000_01_00));
        vecs.push_back(mk("fwd_x0",      0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0, 0, 12'b0_0000_000_00_00));
        vecs.push_back(mk("fwd_wb_b",    0, 0, 0, 9, 0, 2'b00, 0, 9, 0, 9, 1, 0, 0, 12'b0_0000_000_00_01));
        vecs.push_back(mk("fwd_mix",     0, 0, 3, 9, 0, 2'b00, 0, 9, 1, 3, 1, 0, 0, 12'b0_0000_000_01_10));
        vecs.push_back(mk("lu_rs2",      0, 7, 0, 0, 7, 2'b11, 0, 0, 0, 0, 0, 0, 0, 12'b0_1100_010_00_00));
        vecs.push_back(mk("lu_rs1",      7, 0, 0, 0, 7, 2'b11, 0, 0, 0, 0, 0, 0, 0, 12'b0_1100_010_00_00));
        vecs.push_back(mk("lu_x0",       0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 12'b0_0000_000_00_00));
        vecs.push_back(mk("lu_notload",  7, 0, 0, 0, 7, 2'b01, 0, 0, 0, 0, 0, 0, 0, 12'b0_0000_000_00_00));
        vecs.push_back(mk("redir_lu",    0, 7, 0, 0, 7, 2'b11, 1, 0, 0, 0, 0, 0, 0, 12'b0_0000_110_00_00));
        vecs.push_back(mk("redir",       0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 12'b0_0000_110_00_00));
        vecs.push_back(mk("zero_wait",   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 12'b1_0000_000_00_00));
        vecs.push_back(mk("zw_redir",    0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1, 1, 12'b1_0000_110_00_00));
        vecs.push_back(mk("ready_idle",  0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 12'b0_0000_000_00_00));

        do_reset();
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_fault", 32'(bus.mem_fault), 32'd0);
        next_cycle();

        foreach (vecs[i]) begin
            apply(vecs[i]);
            check_cycle(vecs[i].name, vecs[i].exp);
        end

        // One bubble per load-use pair: the bubble clears E's load, so the stall drops.
        do_reset();
        apply(vecs[6]);
        check_cycle("lu_bubble", 12'b0_1100_010_00_00);
        bus.ex_wb_src = 2'b00;
        bus.ex_rd     = 5'd0;
        check_cycle("lu_after", 12'b0_0000_000_00_00);
        clear_inputs();
`ifdef PIPE_PERF_CNT_EN
        @(negedge clk);
        check("perf_lu_cnt", load_use_cnt, 32'd1);
        check("perf_lu_stall", stall_cycles, 32'd1);
        check("perf_lu_flush", flush_events, 32'd0);
        next_cycle();
`endif

        // Three wait cycles with a redirect frozen in E, then completion plus a second redirect.
        do_reset();
        bus.mem_access  = 1'b1;
        bus.dmem_ready  = 1'b0;
        bus.ex_redirect = 1'b1;
        for (int k = 0; k < 3; k++) check_cycle($sformatf("wait_%0d", k), 12'b1_1111_001_00_00);
        bus.dmem_ready = 1'b1;
        check_cycle("wait_done", 12'b1_0000_110_00_00);
        bus.mem_access = 1'b0;
        bus.dmem_ready = 1'b0;
        check_cycle("redir_2", 12'b0_0000_110_00_00);
        clear_inputs();
        @(negedge clk);
        check("back_to_run", 32'(outs()), 32'd0);
`ifdef PIPE_PERF_CNT_EN
        check("perf_stall", stall_cycles, 32'd3);
        check("perf_flush", flush_events, 32'd2);
        check("perf_lu_zero", load_use_cnt, 32'd0);
`endif
        next_cycle();

        // Timeout: one RUN stall cycle then four WAIT cycles before FAULT.
        do_reset();
        bus.mem_access = 1'b1;
        bus.dmem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("tmo_stall_%0d", k), 32'(outs()), 32'(12'b1_1111_001_00_00));
            check($sformatf("tmo_nofault_%0d", k), 32'(bus.mem_fault), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check("fault_outs", 32'(outs()), 32'(12'b0_1111_001_00_00));
        check("fault_flag", 32'(bus.mem_fault), 32'd1);
        next_cycle();
        bus.mem_access = 1'b0;
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        check("fault_sticky_outs", 32'(outs()), 32'(12'b0_1111_001_00_00));
        check("fault_sticky_flag", 32'(bus.mem_fault), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("fault_rst_flag", 32'(bus.mem_fault), 32'd0);
        check("fault_rst_outs", 32'(outs()), 32'd0);
        rst = 1'b0;
        next_cycle();

        // Reset asserted mid-WAIT forces RUN at once; dmem_req then follows mem_access.
        clear_inputs();
        bus.mem_access = 1'b1;
        next_cycle();
        next_cycle();
        bus.mem_access = 1'b0;
        rst = 1'b1;
        #1;
        check("midwait_rst_idle", 32'(outs()), 32'd0);
        bus.mem_access = 1'b1;
        #1;
        check("midwait_rst_req", 32'(outs()), 32'(12'b1_1111_001_00_00));
        clear_inputs();
        rst = 1'b0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
